mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer and arbiter for the single byte-wide RAM port, shared between the instruction fetcher and the load/store unit. It serializes 1/2/4-byte transfers into per-byte RAM cycles and stalls writes to the IO region while the IO buffer is full. Fetch requests can be aborted by a pipeline flush. The LSU has priority, but a starvation counter guarantees fetch progress. It sits between the fetcher/LSU and the top-level RAM/IO pins.

## Interface
- STARVE_LIMIT, 8: consecutive LSU grants allowed while `if_req` is pending before fetch is forced.
- IO_PREFIX, 2'b11: value of `addr[17:16]` identifying IO-mapped addresses.

- clk_in  in  1  clock; all logic on the rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global enable; 0 freezes every register.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write, 0 = read.
- io_buffer_full  in  1  IO sink cannot accept a byte.
- if_req  in  1  fetch request, level.
- if_addr  in  32  fetch word address.
- if_flush  in  1  abort any fetch.
- if_done  out  1  one-cycle pulse; `if_data` valid.
- if_data  out  32  fetched word, little-endian.
- ls_req  in  1  LSU request, level.
- ls_we  in  1  1 = store.
- ls_size  in  2  0 = byte, 1 = half, 2 or 3 = word.
- ls_addr  in  32  LSU byte address.
- ls_wdata  in  32  store data; low N bytes used.
- ls_done  out  1  one-cycle pulse.
- ls_rdata  out  32  load data, zero-extended.

## Operation
- States: IDLE, READ, WRITE, DONE. The latched transaction fields are owner, base address A, byte count N (1, 2 or 4), write data, and byte indices.
- Reset values:
  - All outputs are 0.
  - State is IDLE and the starvation counter is 0.
- Arbitration happens in IDLE only. The choice is made in this order:
  - If `if_flush` is high, `if_req` is ignored.
  - If the starvation counter equals STARVE_LIMIT and `if_req` is high, fetch is granted.
  - Otherwise `ls_req` wins, then `if_req`.
- Starvation counter:
  - Increments on each LSU grant while `if_req` is high.
  - Clears on a fetch grant or any IDLE cycle with `if_req` low.
- Grant edge:
  - Operands are latched.
  - `mem_a` is set to A and `mem_wr` is set to `ls_we`.
  - For a store, `mem_dout` is set to byte 0 of the write data.
  - Next state is READ or WRITE.
- READ: issues addresses A+1 .. A+N-1 on successive edges. Byte k is captured from `mem_din` on the second edge after A+k was driven, at position [8k+7:8k]. After the last capture, the owner's done/data registers are set and the next state is DONE.
- WRITE:
  - Byte k is driven with A+k on successive edges.
  - For an IO address with `io_buffer_full` high, that edge drives `mem_wr` to 0 and the byte index does not advance; the byte is retried.
  - After byte N-1 has been issued, the next edge sets `mem_wr` to 0, pulses `ls_done`, and moves to DONE.
- DONE: done outputs clear, no arbitration this cycle, then IDLE. The requester drops `req` upon seeing `done`.
- Flush:
  - If `if_flush` is high while the owner is fetch in READ, the next edge goes to IDLE. `if_done` is not pulsed and `mem_a` is cleared.
  - LSU transactions ignore flush.
- Address arithmetic is a 32-bit add with wrap: 0xFFFFFFFF+1 = 0.
- When `rdy_in` = 0, every register holds, including `mem_wr`.

## Timing
- Read of N bytes: done is asserted N+1 edges after the grant edge (word read: done visible 5 cycles after grant).
- Write of N bytes with no IO stall: `ls_done` is asserted N edges after the grant edge. Each stall cycle adds one.
- Minimum spacing between grants is N+3 cycles for reads and N+2 for writes, because of the DONE bubble.
- `ls_rdata` and `if_data` hold their values until the next completion by the same owner.
- Requests sampled in the DONE cycle are ignored, so a held `req` is never double-granted.

## Test plan
- Word fetch: RAM[0x100..0x103] = 13,00,50,00 and `if_req` with `if_addr` = 0x100. Expect `mem_a` to step 0x100..0x103, then `if_done` = 1 with `if_data` = 0x00500013, 5 cycles after grant.
- Half load and byte store:
  - Load with `ls_size` = 1 at 0x200 over bytes FE,80 returns `ls_rdata` = 0x000080FE.
  - Store of byte 0xAB at 0x204 drives `mem_wr` = 1 for exactly one cycle; `ls_done` follows 1 edge later.
- Simultaneous requests:
  - With `ls_req` and `if_req` both high and STARVE_LIMIT = 2, with `ls_req` re-asserted 1 cycle after each `ls_done` and `if_req` held (LSU request arriving before the DONE bubble ends), the grant order is LSU, LSU, fetch, LSU.
  - If `ls_req` is asserted 2 or more cycles after each `ls_done` (so it is low on the first IDLE cycle after DONE), fetch wins that cycle and the counter clears.
- IO stall: word store to 0x30000 with `io_buffer_full` high for 3 cycles after byte 1. Bytes 2–3 are delayed, there are no duplicate writes, and `ls_done` comes 7 edges after grant.
- Flush: `if_flush` after the second fetch byte returns the block to IDLE with no `if_done`. A pending `ls_req` is then granted on the following edge.
- Reset mid-write: `rst_in` during WRITE clears `mem_wr`/`mem_a` at the next edge, with no `done` pulses; a subsequent request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: byte-wide RAM port sequencer shared by fetch and LSU.
// Splits 1/2/4-byte transfers into byte cycles, stalls IO writes on full.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic [1:0]  IO_PREFIX    = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] starve;
  logic          owner_if;
  logic [31:0]   base;
  logic [31:0]   wdata;
  logic [31:0]   rbuf;
  logic [31:0]   rbuf_nxt;
  logic [31:0]   rd_addr;
  logic [31:0]   wr_addr;
  logic [2:0]    n;
  logic [2:0]    cnt;
  logic [2:0]    e;
  logic [1:0]    cap;
  logic [2:0]    idx;
  logic [2:0]    size_n;
  logic          fetch_ok;
  logic          starve_hit;
  logic          pick_if;
  logic          pick_ls;
  logic          grant;
  logic          flush_rd;
  logic          rd_last;
  logic          wr_end;
  logic          stall;

  // Arbitration, byte-step bookkeeping and next-state selection.
  always_comb begin
    fetch_ok   = if_req & ~if_flush;
    starve_hit = (starve == SW'(STARVE_LIMIT));
    pick_if    = fetch_ok & (starve_hit | ~ls_req);
    pick_ls    = ls_req & ~pick_if;
    grant      = pick_if | pick_ls;
    case (ls_size)
      2'd0:    size_n = 3'd1;
      2'd1:    size_n = 3'd2;
      default: size_n = 3'd4;
    endcase
    e        = cnt + 3'd1;
    cap      = e[1:0] - 2'd2;
    rd_last  = (e == n + 3'd1);
    rd_addr  = base + {29'd0, e};
    flush_rd = owner_if & if_flush;
    rbuf_nxt = rbuf;
    if (e >= 3'd2) begin
      rbuf_nxt[{cap, 3'b000} +: 8] = mem_din;
    end
    wr_addr   = base + {29'd0, idx};
    stall     = (wr_addr[17:16] == IO_PREFIX) & io_buffer_full;
    wr_end    = (idx == n);
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = (pick_ls & ls_we) ? WRITE : READ;
        end
      end
      READ: begin
        if (flush_rd) begin
          state_nxt = IDLE;
        end else if (rd_last) begin
          state_nxt = DONE;
        end
      end
      WRITE: begin
        if (wr_end) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else if (rdy_in) begin
      state <= state_nxt;
    end
  end

  // Transaction latches, RAM pins, starvation counter and results.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve   <= '0;
      owner_if <= 1'b0;
      base     <= '0;
      wdata    <= '0;
      rbuf     <= '0;
      n        <= '0;
      cnt      <= '0;
      idx      <= '0;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
      mem_dout <= '0;
      if_done  <= 1'b0;
      if_data  <= '0;
      ls_done  <= 1'b0;
      ls_rdata <= '0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (pick_if || !if_req) begin
            starve <= '0;
          end else if (pick_ls && !starve_hit) begin
            starve <= starve + SW'(1);
          end
          if (grant) begin
            owner_if <= pick_if;
            base     <= pick_if ? if_addr : ls_addr;
            mem_a    <= pick_if ? if_addr : ls_addr;
            n        <= pick_if ? 3'd4 : size_n;
            wdata    <= ls_wdata;
            mem_wr   <= pick_ls & ls_we;
            cnt      <= '0;
            idx      <= 3'd1;
            rbuf     <= '0;
            if (pick_ls && ls_we) begin
              mem_dout <= ls_wdata[7:0];
            end
          end
        end
        READ: begin
          if (flush_rd) begin
            mem_a <= '0;
          end else begin
            cnt  <= e;
            rbuf <= rbuf_nxt;
            if (e < n) begin
              mem_a <= rd_addr;
            end
            if (rd_last) begin
              if (owner_if) begin
                if_done <= 1'b1;
                if_data <= rbuf_nxt;
              end else begin
                ls_done  <= 1'b1;
                ls_rdata <= rbuf_nxt;
              end
            end
          end
        end
        WRITE: begin
          if (wr_end) begin
            mem_wr  <= 1'b0;
            ls_done <= 1'b1;
          end else if (stall) begin
            mem_wr <= 1'b0;
          end else begin
            mem_a    <= wr_addr;
            mem_dout <= wdata[{idx[1:0], 3'b000} +: 8];
            mem_wr   <= 1'b1;
            idx      <= idx + 3'd1;
          end
        end
        default: begin
          if_done <= 1'b0;
          ls_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
